// File: rtl/oled_screen_sequencer.sv
// Frame-synchronous menu/board screen sequencer with left-to-right column wipes.
// Optional board border: compile with OLED_SEQ_BORDER_EN defined.
module oled_screen_sequencer #(
    parameter int          WIDTH      = 96,
    parameter int          HEIGHT     = 64,
    parameter int          WIPE_STEP  = 8,
    parameter logic [15:0] BORDER_COL = 16'hF800
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        frame_begin,
    input  logic [12:0] pixel_index,
    input  logic        start_req,
    input  logic [15:0] menu_data,
    input  logic [15:0] board_data,
    output logic [15:0] pixel_data,
    output logic [1:0]  screen_state,
    output logic        board_active,
    output logic        busy,
    output logic        transition_done
);

    typedef enum logic [1:0] {
        S_MENU     = 2'd0,
        S_WIPE_IN  = 2'd1,
        S_BOARD    = 2'd2,
        S_WIPE_OUT = 2'd3
    } state_e;

    localparam logic [12:0] NPIX   = 13'(WIDTH * HEIGHT);
    localparam logic [12:0] W13    = 13'(WIDTH);
    localparam logic [7:0]  STEP8  = 8'(WIPE_STEP);
    localparam logic [7:0]  WIDTH8 = 8'(WIDTH);

    state_e      state_q, state_d;
    logic [6:0]  wipe_col_q, wipe_col_d;
    logic [15:0] pixel_q, pixel_d;
    logic        done_q, done_d;

    logic [7:0]  wipe_sum;
    logic        wipe_last;
    logic [12:0] x;
    logic        in_range;
    logic        revealed;
    logic        border_hit;

    // 8-bit sum keeps the end-of-wipe compare free of 7-bit wrap
    assign wipe_sum  = {1'b0, wipe_col_q} + STEP8;
    assign wipe_last = (wipe_sum >= WIDTH8);

    assign x        = pixel_index % W13;
    assign in_range = (pixel_index < NPIX);
    assign revealed = (x < {6'd0, wipe_col_q});

`ifdef OLED_SEQ_BORDER_EN
    localparam logic [12:0] XMAX     = 13'(WIDTH - 1);
    localparam logic [12:0] LAST_ROW = 13'((HEIGHT - 1) * WIDTH);

    assign border_hit = (x == 13'd0) || (x == XMAX) ||
                        (pixel_index < W13) ||
                        (pixel_index >= LAST_ROW);
`else
    assign border_hit = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        wipe_col_d = wipe_col_q;
        done_d     = 1'b0;
        if (frame_begin) begin
            unique case (state_q)
                S_MENU: begin
                    if (start_req) begin
                        state_d    = S_WIPE_IN;
                        wipe_col_d = '0;
                    end
                end
                S_BOARD: begin
                    if (!start_req) begin
                        state_d    = S_WIPE_OUT;
                        wipe_col_d = '0;
                    end
                end
                S_WIPE_IN, S_WIPE_OUT: begin
                    if (wipe_last) begin
                        state_d    = (state_q == S_WIPE_IN) ? S_BOARD : S_MENU;
                        wipe_col_d = '0;
                        done_d     = 1'b1;
                    end else begin
                        wipe_col_d = wipe_sum[6:0];
                    end
                end
                default: state_d = S_MENU;
            endcase
        end
    end

    // Pixel mux always looks at the pre-edge state
    always_comb begin
        pixel_d = '0;
        if (in_range) begin
            unique case (state_q)
                S_MENU:     pixel_d = menu_data;
                S_BOARD:    pixel_d = border_hit ? BORDER_COL : board_data;
                S_WIPE_IN:  pixel_d = revealed ? board_data : menu_data;
                S_WIPE_OUT: pixel_d = revealed ? menu_data : board_data;
                default:    pixel_d = '0;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_MENU;
            wipe_col_q <= '0;
            pixel_q    <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wipe_col_q <= wipe_col_d;
            pixel_q    <= pixel_d;
            done_q     <= done_d;
        end
    end

    assign pixel_data      = pixel_q;
    assign screen_state    = state_q;
    assign board_active    = (state_q == S_BOARD);
    assign busy            = (state_q == S_WIPE_IN) || (state_q == S_WIPE_OUT);
    assign transition_done = done_q;

endmodule
